// File: rtl/eurosparacentimos.sv
// eurosparacentimos: converts a price given as whole euros plus cents into a
// single cents total (eurosinteiros*100 + eurosfracao). The multiply by 100 is
// done serially with a 7-step shift-add over the constant bits, LSB first,
// followed by one step that adds the cents part. A fractional part above 99 is
// rejected in IDLE with an immediate done/erro pulse.
module eurosparacentimos #(
  parameter int EURO_W = 10,
  parameter int OUT_W  = EURO_W + 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [EURO_W-1:0] eurosinteiros,
  input  logic [EURO_W-1:0] eurosfracao,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  centimos,
  output logic              erro
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ADD  = 2'd2
  } state_t;

  // Multiplier constant, walked one bit per MULT cycle starting at bit 0.
  localparam logic [6:0] MULT_K    = 7'd100;
  localparam logic [2:0] LAST_STEP = 3'd6;

  state_t              state_q,    state_d;
  logic [EURO_W-1:0]   inteiros_q, inteiros_d;
  logic [EURO_W-1:0]   fracao_q,   fracao_d;
  logic [OUT_W-1:0]    acc_q,      acc_d;
  logic [2:0]          step_q,     step_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic [OUT_W-1:0]    centimos_q, centimos_d;
  logic                erro_q,     erro_d;

  // Next-state and datapath: accept/reject in IDLE, shift-add in MULT, finish in ADD.
  always_comb begin
    state_d    = state_q;
    inteiros_d = inteiros_q;
    fracao_d   = fracao_q;
    acc_d      = acc_q;
    step_d     = step_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    centimos_d = centimos_q;
    erro_d     = erro_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (eurosfracao <= EURO_W'(99)) begin
            inteiros_d = eurosinteiros;
            fracao_d   = eurosfracao;
            acc_d      = '0;
            step_d     = '0;
            erro_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = MULT;
          end else begin
            centimos_d = '0;
            erro_d     = 1'b1;
            done_d     = 1'b1;
          end
        end
      end

      MULT: begin
        if (MULT_K[step_q]) begin
          acc_d = acc_q + (OUT_W'(inteiros_q) << step_q);
        end
        step_d = step_q + 3'd1;
        if (step_q == LAST_STEP) begin
          state_d = ADD;
        end
      end

      ADD: begin
        centimos_d = acc_q + OUT_W'(fracao_q);
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      inteiros_q <= '0;
      fracao_q   <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      centimos_q <= '0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inteiros_q <= inteiros_d;
      fracao_q   <= fracao_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      centimos_q <= centimos_d;
      erro_q     <= erro_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign centimos = centimos_q;
  assign erro     = erro_q;

endmodule

// File: tb/tb_eurosparacentimos.sv
// Testbench for eurosparacentimos: directed scenarios plus a randomized run,
// checked against cents = euros*100 + fraction, fraction > 99 rejected.
module tb_eurosparacentimos;

  localparam int EURO_W = 10;
  localparam int OUT_W  = EURO_W + 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [EURO_W-1:0] eurosinteiros;
  logic [EURO_W-1:0] eurosfracao;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  centimos;
  logic              erro;

  int tests = 0;
  int fails = 0;

  eurosparacentimos #(.EURO_W(EURO_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .eurosinteiros(eurosinteiros),
    .eurosfracao  (eurosfracao),
    .busy         (busy),
    .done         (done),
    .centimos     (centimos),
    .erro         (erro)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen or the budget runs out; n = edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  // Reference: valid requests give euros*100 + cents.
  function automatic logic [OUT_W-1:0] ref_cents(input int e, input int f);
    return OUT_W'(e * 100 + f);
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; eurosinteiros = '0; eurosfracao = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (centimos !== '0) begin fails++; $display("FAIL reset_centimos got=%0d exp=0", centimos); end
    tests++; if (erro !== 1'b0) begin fails++; $display("FAIL reset_erro got=%b exp=0", erro); end
  endtask

  task automatic test_basic();
    eurosinteiros = 10'd4; eurosfracao = 10'd70; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++; if (busy !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL basic_busy cycle=%0d got busy=%b done=%b exp busy=1 done=0", i + 1, busy, done);
      end
      tick();
    end
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    tests++; if (centimos !== ref_cents(4, 70)) begin fails++; $display("FAIL basic_value got=%0d exp=470", centimos); end
    tests++; if (erro !== 1'b0) begin fails++; $display("FAIL basic_erro got=%b exp=0", erro); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_boundary();
    int n;
    eurosinteiros = 10'd0; eurosfracao = 10'd0; start = 1'b1;
    tick();
    eurosinteiros = 10'd1023; eurosfracao = 10'd99;
    wait_done(n);
    tests++; if (n !== 8) begin fails++; $display("FAIL bnd_zero_latency got=%0d exp=8", n); end
    tests++; if (centimos !== '0) begin fails++; $display("FAIL bnd_zero_value got=%0d exp=0", centimos); end
    tick();
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bnd_b2b_accept got busy=%b exp=1", busy); end
    wait_done(n);
    tests++; if (n !== 8) begin fails++; $display("FAIL bnd_max_latency got=%0d exp=8", n); end
    tests++; if (centimos !== ref_cents(1023, 99)) begin fails++; $display("FAIL bnd_max_value got=%0d exp=102399", centimos); end
    tests++; if (erro !== 1'b0) begin fails++; $display("FAIL bnd_max_erro got=%b exp=0", erro); end
    tick();
  endtask

  task automatic test_invalid();
    int n;
    eurosinteiros = 10'd3; eurosfracao = 10'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (done !== 1'b1 || erro !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL inv_flags got done=%b erro=%b busy=%b exp 1 1 0", done, erro, busy);
    end
    tests++; if (centimos !== '0) begin fails++; $display("FAIL inv_value got=%0d exp=0", centimos); end
    tick();
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL inv_after got done=%b busy=%b exp 0 0", done, busy);
    end
    tests++; if (erro !== 1'b1) begin fails++; $display("FAIL inv_erro_hold got=%b exp=1", erro); end
    eurosinteiros = 10'd2; eurosfracao = 10'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    tests++; if (n !== 8) begin fails++; $display("FAIL inv_follow_latency got=%0d exp=8", n); end
    tests++; if (centimos !== ref_cents(2, 5) || erro !== 1'b0) begin
      fails++; $display("FAIL inv_follow got=%0d erro=%b exp=205 erro=0", centimos, erro);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    int n;
    int extra;
    eurosinteiros = 10'd12; eurosfracao = 10'd34; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    eurosinteiros = 10'd7; eurosfracao = 10'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    tests++; if (n !== 5) begin fails++; $display("FAIL busy_ign_latency got=%0d exp=5", n); end
    tests++; if (centimos !== ref_cents(12, 34)) begin fails++; $display("FAIL busy_ign_value got=%0d exp=1234", centimos); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL busy_ign_second got=%0d active cycles exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int extra;
    eurosinteiros = 10'd9; eurosfracao = 10'd99; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy got=%b exp=1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || erro !== 1'b0) begin
      fails++; $display("FAIL rst_mid_flags got busy=%b done=%b erro=%b exp 0 0 0", busy, done, erro);
    end
    tests++; if (centimos !== '0) begin fails++; $display("FAIL rst_mid_value got=%0d exp=0", centimos); end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL rst_mid_no_done got=%0d exp=0", extra); end
  endtask

  task automatic test_held_start();
    int n;
    eurosinteiros = 10'd5; eurosfracao = 10'd50; start = 1'b1;
    tick();
    eurosinteiros = 10'd6; eurosfracao = 10'd60;
    wait_done(n);
    tests++; if (n !== 8) begin fails++; $display("FAIL held_first_latency got=%0d exp=8", n); end
    tests++; if (centimos !== ref_cents(5, 50)) begin fails++; $display("FAIL held_first got=%0d exp=550", centimos); end
    tick();
    wait_done(n);
    start = 1'b0;
    tests++; if (n + 1 !== 9) begin fails++; $display("FAIL held_spacing got=%0d exp=9", n + 1); end
    tests++; if (centimos !== ref_cents(6, 60)) begin fails++; $display("FAIL held_second got=%0d exp=660", centimos); end
    tick();
  endtask

  task automatic test_random();
    int n;
    int e;
    int f;
    for (int k = 0; k < 40; k++) begin
      e = int'($urandom_range(0, 1023));
      f = int'($urandom_range(0, 127));
      eurosinteiros = EURO_W'(e); eurosfracao = EURO_W'(f); start = 1'b1;
      tick();
      start = 1'b0;
      eurosinteiros = EURO_W'($urandom); eurosfracao = EURO_W'($urandom);
      if (f > 99) begin
        tests++; if (done !== 1'b1 || erro !== 1'b1 || busy !== 1'b0 || centimos !== '0) begin
          fails++; $display("FAIL rnd_invalid k=%0d f=%0d got done=%b erro=%b busy=%b c=%0d exp 1 1 0 0",
                            k, f, done, erro, busy, centimos);
        end
      end else begin
        wait_done(n);
        tests++; if (n !== 8 || centimos !== ref_cents(e, f) || erro !== 1'b0) begin
          fails++; $display("FAIL rnd_valid k=%0d %0d/%0d got lat=%0d c=%0d erro=%b exp lat=8 c=%0d erro=0",
                            k, e, f, n, centimos, erro, e * 100 + f);
        end
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_invalid();
    test_ignore_busy();
    test_reset_mid();
    test_held_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eurosparacentimos.md
Name: eurosparacentimos

Overview:
- Sequential converter from a euro amount, given as whole euros plus a fractional part in cents, back to a single cents value: centimos = eurosinteiros*100 + eurosfracao.
- Sits on the Balanca price path, where a price is entered or stored as euros and cents and must be turned into a cents total for weighing arithmetic.
- Multiplies by 100 with a 7-step shift-add sequence instead of a combinational multiplier.
- Uses a start/busy/done handshake and flags an invalid fractional part.

Parameters:
- EURO_W, 10, width of eurosinteiros and eurosfracao.
- OUT_W, EURO_W+7, width of centimos. Fixed relationship; the result cannot overflow.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- eurosinteiros  input  EURO_W  whole euros, unsigned, 0..2^EURO_W-1.
- eurosfracao  input  EURO_W  cents part, unsigned; valid range 0..99.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when centimos/erro are updated.
- centimos  output  OUT_W  result in cents; held until the next done.
- erro  output  1  high if the last accepted request had eurosfracao > 99.

Behaviour:
- One clock domain, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, centimos=0, erro=0, internal accumulator/counter=0. Reset has priority over everything, including mid-conversion; an aborted conversion produces no done.
- States: IDLE, MULT, ADD.
- IDLE, start=1, eurosfracao<=99:
  - capture both inputs into internal registers; acc=0; step=0; erro<=0; busy<=1; go to MULT.
  - Inputs may change freely after the capture edge.
- IDLE, start=1, eurosfracao>99:
  - stay in IDLE; on the same edge centimos<=0, erro<=1, done<=1; busy stays 0.
  - Latency is 1 edge.
- MULT, one constant bit per edge, LSB first, over the constant 100 = 1100100b:
  - if bit[step]=1, acc += eurosinteiros_reg << step.
  - step increments each edge.
  - After step 6 (7 edges in total), go to ADD.
  - acc is OUT_W wide; no truncation.
- ADD: centimos <= acc + eurosfracao_reg; done<=1; busy<=0; go to IDLE.
- Valid-request latency: done is high in the cycle following the 8th rising edge after the accepting edge. busy is high for exactly 8 cycles.
- done is high for exactly one cycle, then returns to 0.
- centimos and erro hold their values until the next done or reset.
- start while busy=1 is ignored; no queuing.
- start high in the same cycle done is high: state is already IDLE, so the request is accepted normally (back-to-back throughput is 1 result per 9 cycles).
- start held high continuously: a new conversion starts each time IDLE is reached.
- Maximum result: (2^EURO_W-1)*100+99 = 102399 for EURO_W=10, which fits in 17 bits.

Test Plan:
- Basic conversion:
  - stimulus: reset 2 cycles; eurosinteiros=4, eurosfracao=70, start pulsed 1 cycle.
  - response: busy=1 for 8 cycles; done pulse in the 9th cycle; centimos=470; erro=0.
- Boundary values, both back-to-back with no gap:
  - eurosinteiros=0, eurosfracao=0 -> centimos=0.
  - then eurosinteiros=1023, eurosfracao=99 -> centimos=102399, erro=0.
- Invalid fraction:
  - stimulus: eurosinteiros=3, eurosfracao=100, start.
  - response: next cycle done=1, erro=1, centimos=0, busy never asserted.
  - follow-up: a valid 2/5 request -> centimos=205, erro=0.
- start ignored while busy:
  - stimulus: start 12/34; pulse start again with 7/7 during busy.
  - response: single done with centimos=1234; no second done.
- Reset mid-operation:
  - stimulus: start 9/99; assert reset on the 4th busy cycle.
  - response: next cycle busy=0, done=0, centimos=0, erro=0; no done pulse afterwards.
- Held start / inputs changing after capture:
  - stimulus: start held high with 5/50, inputs changed to 6/60 one cycle after acceptance.
  - response: first done gives 550, second done gives 660, with done pulses 9 cycles apart.
